// File: rtl/cv32e40p_x_if_pkg.sv
// Shared X-interface types and xmem encodings used by the memory responder and its neighbours.
package cv32e40p_x_if_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;

  localparam logic [2:0] XMEM_W_BYTE = 3'd0;
  localparam logic [2:0] XMEM_W_HALF = 3'd1;
  localparam logic [2:0] XMEM_W_WORD = 3'd2;

  localparam logic XMEM_OK  = 1'b0;
  localparam logic XMEM_ERR = 1'b1;

  typedef struct packed {
    logic [1:0]  offset;
    logic [2:0]  width;
    logic        we;
    logic        err;
    logic        done;
    logic [31:0] rdata;
  } xmem_entry_t;

endpackage

// File: rtl/cv32e40p_xmem_responder_if.sv
// Bundle of the xmem request/response channel and the core OBI data port seen by the responder.
interface cv32e40p_xmem_responder_if;
  import cv32e40p_x_if_pkg::*;

  logic          xmem_valid;
  logic          xmem_ready;
  logic [31:0]   xmem_laddr;
  logic [31:0]   xmem_wdata;
  logic [2:0]    xmem_width;
  mem_req_type_e xmem_req_type;
  logic          xmem_mode;
  logic          xmem_spec;
  logic          xmem_endoftransaction;
  logic          xmem_rvalid;
  logic          xmem_rready;
  logic [31:0]   xmem_rdata;
  logic [4:0]    xmem_range;
  logic          xmem_status;

  logic          data_req;
  logic          data_we;
  logic          data_gnt;
  logic          data_rvalid;
  logic [31:0]   data_addr;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata;
  logic [31:0]   data_rdata;

  modport slave (
    input  xmem_valid, xmem_laddr, xmem_wdata, xmem_width, xmem_req_type,
           xmem_mode, xmem_spec, xmem_endoftransaction, xmem_rready,
           data_gnt, data_rvalid, data_rdata,
    output xmem_ready, xmem_rvalid, xmem_rdata, xmem_range, xmem_status,
           data_req, data_we, data_addr, data_be, data_wdata
  );

  modport master (
    output xmem_valid, xmem_laddr, xmem_wdata, xmem_width, xmem_req_type,
           xmem_mode, xmem_spec, xmem_endoftransaction, xmem_rready,
           data_gnt, data_rvalid, data_rdata,
    input  xmem_ready, xmem_rvalid, xmem_rdata, xmem_range, xmem_status,
           data_req, data_we, data_addr, data_be, data_wdata
  );

endinterface

// File: rtl/cv32e40p_xmem_align.sv
// Byte-lane alignment for xmem: request legality, byte enables and store shift,
// load extraction for the entry being completed, and the range code of the head entry.
module cv32e40p_xmem_align
  import cv32e40p_x_if_pkg::*;
(
  input  logic [1:0]  req_offset,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_sh,
  output logic        req_illegal,

  input  logic [1:0]  rsp_offset,
  input  logic [2:0]  rsp_width,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_ext,

  input  logic [2:0]  out_width,
  output logic [4:0]  out_range
);

  logic [3:0]  be_base;
  logic [31:0] rdata_sh;

  always_comb begin
    be_base     = 4'h0;
    req_illegal = 1'b0;
    case (req_width)
      XMEM_W_BYTE: be_base = 4'h1;
      XMEM_W_HALF: begin
        be_base     = 4'h3;
        req_illegal = req_offset[0];
      end
      XMEM_W_WORD: begin
        be_base     = 4'hF;
        req_illegal = |req_offset;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  assign req_be       = be_base << req_offset;
  assign req_wdata_sh = req_wdata << {req_offset, 3'b000};

  assign rdata_sh = rsp_rdata >> {rsp_offset, 3'b000};

  always_comb begin
    rsp_rdata_ext = rdata_sh;
    case (rsp_width)
      XMEM_W_BYTE: rsp_rdata_ext = {24'h0, rdata_sh[7:0]};
      XMEM_W_HALF: rsp_rdata_ext = {16'h0, rdata_sh[15:0]};
      default:     rsp_rdata_ext = rdata_sh;
    endcase
  end

  always_comb begin
    out_range = 5'd0;
    case (out_width)
      XMEM_W_BYTE: out_range = 5'd7;
      XMEM_W_HALF: out_range = 5'd15;
      XMEM_W_WORD: out_range = 5'd31;
      default:     out_range = 5'd0;
    endcase
  end

endmodule

// File: rtl/cv32e40p_xmem_responder.sv
// Core-side xmem responder: issues coprocessor loads/stores on the OBI data port and
// returns responses in acceptance order from a small circular buffer.
module cv32e40p_xmem_responder
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2
) (
  input logic                       clk,
  input logic                       rst,
  cv32e40p_xmem_responder_if.slave  bus
);

  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  xmem_entry_t   entries [OUTSTANDING];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;
  logic [2:0]    settle_cnt;

  logic          alloc_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          rsp_hit;
  logic          tgt_found;
  logic [PW-1:0] tgt_ptr;
  logic          head_valid;
  logic          req_illegal;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata_sh;
  logic [31:0]   rsp_rdata_ext;
  logic [4:0]    out_range;
  logic          unused_hints;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  cv32e40p_xmem_align u_align (
    .req_offset    (bus.xmem_laddr[1:0]),
    .req_width     (bus.xmem_width),
    .req_wdata     (bus.xmem_wdata),
    .req_be        (req_be),
    .req_wdata_sh  (req_wdata_sh),
    .req_illegal   (req_illegal),
    .rsp_offset    (entries[tgt_ptr].offset),
    .rsp_width     (entries[tgt_ptr].width),
    .rsp_rdata     (bus.data_rdata),
    .rsp_rdata_ext (rsp_rdata_ext),
    .out_width     (entries[head_ptr].width),
    .out_range     (out_range)
  );

  // Slots freed by a pop only become usable next cycle, keeping rready off the ready path.
  assign alloc_ok = (count < CW'(OUTSTANDING));
  assign issue    = bus.xmem_valid & alloc_ok & ~rst;

  assign bus.data_req   = issue & ~req_illegal;
  assign bus.xmem_ready = req_illegal ? issue : (issue & bus.data_gnt);
  assign bus.data_addr  = {bus.xmem_laddr[31:2], 2'b00};
  assign bus.data_be    = req_be;
  assign bus.data_wdata = req_wdata_sh;
  assign bus.data_we    = (bus.xmem_req_type == WRITE);

  assign push = bus.xmem_ready;

  // Oldest allocated entry still waiting on the bus; errored entries never see a response.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_ptr;
    tgt_found = 1'b0;
    tgt_ptr   = '0;
    idx       = 0;
    idx_ptr   = '0;
    for (int i = 0; i < int'(OUTSTANDING); i++) begin
      idx = int'(head_ptr) + i;
      if (idx >= int'(OUTSTANDING)) idx = idx - int'(OUTSTANDING);
      idx_ptr = PW'(idx);
      if (!tgt_found && (i < int'(count)) && !entries[idx_ptr].done && !entries[idx_ptr].err) begin
        tgt_found = 1'b1;
        tgt_ptr   = idx_ptr;
      end
    end
  end

  assign rsp_hit = bus.data_rvalid & tgt_found;

  assign head_valid      = (count != '0);
  assign bus.xmem_rvalid = head_valid & entries[head_ptr].done;
  assign bus.xmem_rdata  = bus.xmem_rvalid ? entries[head_ptr].rdata : 32'h0;
  assign bus.xmem_range  = (bus.xmem_rvalid & ~entries[head_ptr].err) ? out_range : 5'd0;
  assign bus.xmem_status = (bus.xmem_rvalid & entries[head_ptr].err) ? XMEM_ERR : XMEM_OK;

  assign pop = bus.xmem_rvalid & bus.xmem_rready;

  assign unused_hints = ^{bus.xmem_mode, bus.xmem_spec, bus.xmem_endoftransaction};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr  <= '0;
      head_ptr   <= '0;
      count      <= '0;
      settle_cnt <= 3'd0;
      for (int i = 0; i < int'(OUTSTANDING); i++) entries[i] <= '0;
    end else begin
      if (settle_cnt != 3'd4) settle_cnt <= settle_cnt + 3'd1;
      if (push) begin
        entries[alloc_ptr] <= '{offset: bus.xmem_laddr[1:0],
                                width:  bus.xmem_width,
                                we:     (bus.xmem_req_type == WRITE),
                                err:    req_illegal,
                                done:   req_illegal,
                                rdata:  32'h0};
        alloc_ptr <= wrap_inc(alloc_ptr);
      end
      if (rsp_hit) begin
        entries[tgt_ptr].done  <= 1'b1;
        entries[tgt_ptr].rdata <= entries[tgt_ptr].we ? 32'h0 : rsp_rdata_ext;
      end
      if (pop) head_ptr <= wrap_inc(head_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Stale responses right after reset are expected; later ones indicate a protocol error.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    (bus.data_rvalid && !tgt_found) |-> (settle_cnt < 3'd4));

endmodule

// File: tb/tb_cv32e40p_xmem_responder.sv
// Scoreboard bench for the xmem responder: expected responses are queued at acceptance
// and compared as the DUT hands them back.
module tb_cv32e40p_xmem_responder;
  import cv32e40p_x_if_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  range;
    logic        status;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cv32e40p_xmem_responder_if bus();

  cv32e40p_xmem_responder #(.OUTSTANDING(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic resp_t model_resp(input logic [31:0] addr, input logic [2:0] width,
                                       input logic we, input logic [31:0] bus_rdata);
    resp_t       r;
    logic        bad;
    logic [31:0] sh;
    r   = '0;
    bad = (width > 3'd2) || (width == 3'd1 && addr[0]) || (width == 3'd2 && addr[1:0] != 2'b00);
    if (bad) begin
      r.status = 1'b1;
    end else begin
      r.range = (width == 3'd0) ? 5'd7 : (width == 3'd1) ? 5'd15 : 5'd31;
      if (!we) begin
        sh = bus_rdata >> (8 * addr[1:0]);
        r.rdata = (width == 3'd0) ? {24'h0, sh[7:0]} :
                  (width == 3'd1) ? {16'h0, sh[15:0]} : sh;
      end
    end
    return r;
  endfunction

  // Response monitor: runs a few ns after the falling edge, once stimulus has settled.
  logic  prev_hold = 1'b0;
  resp_t prev_out  = '0;

  always @(negedge clk) begin
    resp_t e;
    #3;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_rvalid", bus.xmem_rvalid, 1);
        check_eq("hold_rdata", bus.xmem_rdata, prev_out.rdata);
        check_eq("hold_range", bus.xmem_range, prev_out.range);
        check_eq("hold_status", bus.xmem_status, prev_out.status);
      end
      if (bus.xmem_rvalid && bus.xmem_rready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_rdata", bus.xmem_rdata, e.rdata);
          check_eq("rsp_range", bus.xmem_range, e.range);
          check_eq("rsp_status", bus.xmem_status, e.status);
        end
      end
      prev_hold = bus.xmem_rvalid && !bus.xmem_rready;
      prev_out  = '{rdata: bus.xmem_rdata, range: bus.xmem_range, status: bus.xmem_status};
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [2:0] width,
                           input mem_req_type_e typ, input logic [31:0] wdata);
    bus.xmem_valid    = 1'b1;
    bus.xmem_laddr    = addr;
    bus.xmem_width    = width;
    bus.xmem_req_type = typ;
    bus.xmem_wdata    = wdata;
  endtask

  initial begin
    rst                       = 1'b1;
    bus.xmem_valid            = 1'b0;
    bus.xmem_laddr            = 32'h0;
    bus.xmem_wdata            = 32'h0;
    bus.xmem_width            = 3'd0;
    bus.xmem_req_type         = READ;
    bus.xmem_mode             = 1'b0;
    bus.xmem_spec             = 1'b0;
    bus.xmem_endoftransaction = 1'b0;
    bus.xmem_rready           = 1'b1;
    bus.data_gnt              = 1'b0;
    bus.data_rvalid           = 1'b0;
    bus.data_rdata            = 32'h0;

    // Reset values, with a request pending to show nothing is issued in reset
    cyc();
    drive_req(32'h1000, 3'd2, READ, 32'h0);
    bus.data_gnt = 1'b1;
    #1;
    check_eq("rst_data_req", bus.data_req, 0);
    check_eq("rst_rvalid", bus.xmem_rvalid, 0);
    check_eq("rst_rdata", bus.xmem_rdata, 0);
    check_eq("rst_range", bus.xmem_range, 0);
    check_eq("rst_status", bus.xmem_status, 0);
    cyc();
    bus.xmem_valid = 1'b0;
    bus.data_gnt   = 1'b0;
    rst            = 1'b0;
    cyc();

    // Word load, bus response two cycles after grant
    cyc();
    drive_req(32'h1000, 3'd2, READ, 32'h0);
    bus.data_gnt = 1'b1;
    #1;
    check_eq("s1_data_req", bus.data_req, 1);
    check_eq("s1_ready", bus.xmem_ready, 1);
    check_eq("s1_addr", bus.data_addr, 32'h1000);
    check_eq("s1_be", bus.data_be, 4'hF);
    check_eq("s1_we", bus.data_we, 0);
    exp_q.push_back(model_resp(32'h1000, 3'd2, 1'b0, 32'hDEADBEEF));
    cyc();
    bus.xmem_valid = 1'b0;
    bus.data_gnt   = 1'b0;
    cyc();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hDEADBEEF;
    #1;
    check_eq("s1_rvalid_early", bus.xmem_rvalid, 0);
    cyc();
    bus.data_rvalid = 1'b0;
    #1;
    check_eq("s1_latency", bus.xmem_rvalid, 1);
    cyc();
    #1;
    check_eq("s1_popped", bus.xmem_rvalid, 0);

    // Byte store to the top lane
    cyc();
    drive_req(32'h2003, 3'd0, WRITE, 32'h000000A5);
    bus.data_gnt = 1'b1;
    #1;
    check_eq("s2_ready", bus.xmem_ready, 1);
    check_eq("s2_addr", bus.data_addr, 32'h2000);
    check_eq("s2_be", bus.data_be, 4'b1000);
    check_eq("s2_wdata", bus.data_wdata, 32'hA5000000);
    check_eq("s2_we", bus.data_we, 1);
    exp_q.push_back(model_resp(32'h2003, 3'd0, 1'b1, 32'h12345678));
    cyc();
    bus.xmem_valid  = 1'b0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h12345678;
    cyc();
    bus.data_rvalid = 1'b0;
    #1;
    check_eq("s2_latency", bus.xmem_rvalid, 1);
    cyc();

    // Misaligned half load: never reaches the bus, errors next cycle
    cyc();
    drive_req(32'h3001, 3'd1, READ, 32'h0);
    #1;
    check_eq("s3_data_req", bus.data_req, 0);
    check_eq("s3_ready", bus.xmem_ready, 1);
    exp_q.push_back(model_resp(32'h3001, 3'd1, 1'b0, 32'h0));
    cyc();
    bus.xmem_valid = 1'b0;
    #1;
    check_eq("s3_latency", bus.xmem_rvalid, 1);
    check_eq("s3_status", bus.xmem_status, 1);
    cyc();

    // Buffer full with rready low: third load waits until a slot is popped
    bus.xmem_rready = 1'b0;
    bus.data_gnt    = 1'b1;
    cyc();
    drive_req(32'h4000, 3'd2, READ, 32'h0);
    #1;
    check_eq("s4_ready0", bus.xmem_ready, 1);
    exp_q.push_back(model_resp(32'h4000, 3'd2, 1'b0, 32'h11));
    cyc();
    drive_req(32'h4004, 3'd2, READ, 32'h0);
    #1;
    check_eq("s4_ready1", bus.xmem_ready, 1);
    exp_q.push_back(model_resp(32'h4004, 3'd2, 1'b0, 32'h22));
    cyc();
    drive_req(32'h4008, 3'd2, READ, 32'h0);
    #1;
    check_eq("s4_full_ready", bus.xmem_ready, 0);
    check_eq("s4_full_req", bus.data_req, 0);
    cyc();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h11;
    #1;
    check_eq("s4_held_a", bus.xmem_ready, 0);
    cyc();
    bus.data_rdata = 32'h22;
    #1;
    check_eq("s4_first_done", bus.xmem_rvalid, 1);
    check_eq("s4_held_b", bus.xmem_ready, 0);
    cyc();
    bus.data_rvalid = 1'b0;
    bus.xmem_rready = 1'b1;
    #1;
    check_eq("s4_no_rready_path", bus.xmem_ready, 0);
    cyc();
    #1;
    check_eq("s4_third_accept", bus.xmem_ready, 1);
    exp_q.push_back(model_resp(32'h4008, 3'd2, 1'b0, 32'h33));
    cyc();
    bus.xmem_valid  = 1'b0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h33;
    cyc();
    bus.data_rvalid = 1'b0;
    #1;
    check_eq("s4_third_rvalid", bus.xmem_rvalid, 1);
    cyc();

    // Error entry queued behind a pending load must wait for it
    bus.xmem_rready = 1'b0;
    cyc();
    drive_req(32'h5000, 3'd2, READ, 32'h0);
    bus.data_gnt = 1'b1;
    #1;
    check_eq("s5_load_ready", bus.xmem_ready, 1);
    exp_q.push_back(model_resp(32'h5000, 3'd2, 1'b0, 32'hCAFEF00D));
    cyc();
    drive_req(32'h5002, 3'd3, READ, 32'h0);
    bus.data_gnt = 1'b0;
    #1;
    check_eq("s5_err_ready", bus.xmem_ready, 1);
    check_eq("s5_err_req", bus.data_req, 0);
    exp_q.push_back(model_resp(32'h5002, 3'd3, 1'b0, 32'h0));
    cyc();
    bus.xmem_valid = 1'b0;
    #1;
    check_eq("s5_err_waits_a", bus.xmem_rvalid, 0);
    cyc();
    #1;
    check_eq("s5_err_waits_b", bus.xmem_rvalid, 0);
    cyc();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hCAFEF00D;
    cyc();
    bus.data_rvalid = 1'b0;
    #1;
    check_eq("s5_load_first", bus.xmem_rdata, 32'hCAFEF00D);
    cyc();
    cyc();
    cyc();
    bus.xmem_rready = 1'b1;
    cyc();
    #1;
    check_eq("s5_err_next", bus.xmem_status, 1);
    cyc();
    #1;
    check_eq("s5_drained", bus.xmem_rvalid, 0);

    // Reset with two loads in flight; late bus responses must be dropped
    cyc();
    drive_req(32'h6000, 3'd2, READ, 32'h0);
    bus.data_gnt = 1'b1;
    cyc();
    drive_req(32'h6004, 3'd2, READ, 32'h0);
    cyc();
    drive_req(32'h6008, 3'd2, READ, 32'h0);
    rst = 1'b1;
    #1;
    check_eq("s6_rst_req", bus.data_req, 0);
    check_eq("s6_rst_rvalid", bus.xmem_rvalid, 0);
    cyc();
    #1;
    check_eq("s6_rst_req_b", bus.data_req, 0);
    cyc();
    rst             = 1'b0;
    bus.xmem_valid  = 1'b0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hBAD0BAD0;
    cyc();
    bus.data_rdata = 32'hBAD1BAD1;
    cyc();
    bus.data_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("s6_stale_dropped", bus.xmem_rvalid, 0);
      cyc();
    end

    cyc();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_xmem_responder.md
Name: cv32e40p_xmem_responder

Overview:
- Core-side responder for the X-interface memory channel (xmem).
- Accepts load/store requests offloaded by the coprocessor, drives them onto the core's OBI data port, and returns in-order responses on the xmem response channel.
- Sits beside the load-store unit inside the core wrapper; the core-and-coprocessor wrapper connects it to the coprocessor's xmem_q_*/xmem_p_* ports.

Parameters:
- OUTSTANDING, 2, max requests accepted but not yet returned on xmem_rvalid_o (range 1..8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- xmem_valid_i  in  1  request valid
- xmem_ready_o  out  1  request accepted this cycle
- xmem_laddr_i  in  32  byte address
- xmem_wdata_i  in  32  store data, LSB-aligned
- xmem_width_i  in  3  0=byte, 1=half, 2=word; others illegal
- xmem_req_type_i  in  mem_req_type_e  READ=load, WRITE=store
- xmem_mode_i, xmem_spec_i, xmem_endoftransaction_i  in  1 each  accepted, no effect
- xmem_rvalid_o  out  1  response valid
- xmem_rready_i  in  1  response taken
- xmem_rdata_o  out  32  load data, LSB-aligned, zero-extended; 0 for stores/errors
- xmem_range_o  out  5  (8<<width)-1, i.e. 7/15/31; 0 on error
- xmem_status_o  out  1  0=ok, 1=misaligned/illegal
- data_req_o, data_we_o  out  1  OBI request
- data_gnt_i, data_rvalid_i  in  1  OBI grant/response
- data_addr_o  out  32  word-aligned address
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  store data shifted to byte lane
- data_rdata_i  in  32  OBI read data

Behaviour:
- Reset (rst_i async, high): all entries invalid. Outputs: xmem_rvalid_o=0, xmem_rdata_o=0, xmem_range_o=0, xmem_status_o=0, data_req_o=0.
- Illegal request: width>2, half with laddr[0]=1, or word with laddr[1:0]!=0. Never issued to the bus.
- Buffer: in-order circular buffer of OUTSTANDING entries. Each entry holds {offset, width, we, err, done, rdata}; alloc pointer, head pointer, count.
- alloc_ok = count < OUTSTANDING. A pop in the same cycle does not free a slot, so there is no rready->ready path.
- Legal request:
  - data_req_o = xmem_valid_i & alloc_ok.
  - xmem_ready_o = data_req_o & data_gnt_i.
  - Allocate on that handshake with done=0.
  - data_addr_o = {laddr[31:2],2'b00}.
  - data_be_o = (1/3/F) << laddr[1:0].
  - data_wdata_o = wdata << 8*laddr[1:0].
  - data_we_o = (req_type==WRITE).
- Illegal request: xmem_ready_o = xmem_valid_i & alloc_ok. Allocate with err=1, done=1; data_req_o=0.
- OBI response: data_rvalid_i marks the oldest allocated non-err entry with done=0 as done. For loads, stores rdata = (data_rdata_i >> 8*offset) masked to width. Stores keep rdata=0.
- data_rvalid_i with no pending bus entry is dropped (covers responses after mid-transaction reset). An assertion flags it outside the first 4 cycles after reset.
- Output: xmem_rvalid_o = head entry valid & done, registered from buffer state. Pop on xmem_rvalid_o & xmem_rready_i. Outputs hold stable while rvalid & !rready.
- Latency: data_rvalid_i at cycle N gives xmem_rvalid_o at N+1 if that entry is head. An illegal request accepted at N responds at N+1 if head.
- Ordering: responses are strictly in acceptance order. An error entry behind pending bus entries waits.
- Simultaneous events in one cycle are all legal: allocate, mark done and pop.
- Pointers wrap modulo OUTSTANDING; count width is $clog2(OUTSTANDING+1).

Decomposition:
- Reuse mem_req_type_e from cv32e40p_x_if_pkg.
- Add to cv32e40p_x_if_pkg:
  - xmem width encodings (XMEM_W_BYTE/HALF/WORD)
  - xmem_status codes (XMEM_OK=0, XMEM_ERR=1)
  - struct xmem_entry_t
- One sub-module: cv32e40p_xmem_align, purely combinational. It generates be/wdata shift, load extraction, range, and the illegal check. It is reused by both request and response paths.

Test Plan:
- Word load at 0x1000, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> xmem_rvalid_o one cycle after rvalid, rdata 0xDEADBEEF, range 31, status 0.
- Byte store laddr 0x2003 wdata 0xA5 -> data_addr 0x2000, be 4'b1000, wdata 0xA5000000, we=1; response rdata 0, range 7, status 0.
- Half load at 0x3001 -> no data_req_o, ready same cycle, response next cycle with status 1, range 0, rdata 0.
- OUTSTANDING=2: three back-to-back loads, rready=0 -> third held with xmem_ready_o=0 until first popped. Rvalids 0x11/0x22 then 0x33 returned in order.
- Word load pending plus an illegal request accepted next cycle -> error response only after the load response. Both in order with rready held low 3 cycles, outputs stable.
- Assert rst_i while two loads are in flight, then deliver two stale rvalids -> xmem_rvalid_o stays 0, responses dropped, data_req_o=0 during reset.
